out_port_sched: RTL and testbench

OUT_PORT_SCHED -- requirements
Module: out_port_sched

---
 rtl/out_port_sched.sv | 140 ++++++++++++++
 tb/tb_out_port_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_sched.sv
// out_port_sched: burst scheduler that drains NUM_PORTS input FIFOs into a single output stream.
// Build macro SCHED_PRIO_EN: port 0 wins every arbitration it competes in; default build is pure round-robin.
module out_port_sched #(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           fifo_empty,
  input  logic [NUM_PORTS*W_WIDTH-1:0]   fifo_data,
  input  logic                           out_full,
  output logic [NUM_PORTS-1:0]           rd_en,
  output logic                           out_valid,
  output logic [W_WIDTH-1:0]             out_data,
  output logic [$clog2(NUM_PORTS)-1:0]   grant,
  output logic                           busy
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] vgrant_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ov_q;

  logic          arb_found;
  logic [GW-1:0] arb_idx;
  logic [GW:0]   cand;
  logic [GW-1:0] grant_inc;
  logic          pop;
  logic          burst_done;

  // Handshake: rd_en is a pop strobe with no ready; it is raised only for the granted,
  // non-empty FIFO while downstream is not full. out_valid likewise has no ready:
  // out_full is honoured one cycle early because downstream keeps one entry of slack.

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_PORTS)) begin
        cand = cand - (GW+1)'(NUM_PORTS);
      end
      if (!arb_found && !fifo_empty[cand[GW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[GW-1:0];
      end
    end
`ifdef SCHED_PRIO_EN
    if (!fifo_empty[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
`endif
  end

  always_comb begin
    pop   = (state_q == BURST) && !fifo_empty[grant_q] && !out_full &&
            (cnt_q < CW'(BURST_LEN));
    rd_en = '0;
    if (pop) begin
      rd_en[grant_q] = 1'b1;
    end
  end

  assign grant_inc = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = BURST;
          grant_d = arb_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (pop) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Leaving on the pop that fills the burst keeps the gap between bursts at one cycle.
        burst_done = fifo_empty[grant_q] || (cnt_d == CW'(BURST_LEN));
        if (burst_done) begin
          state_d = IDLE;
`ifdef SCHED_PRIO_EN
          if (grant_q != '0) begin
            rr_d = grant_inc;
          end
`else
          rr_d = grant_inc;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      vgrant_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ov_q     <= |rd_en;
      vgrant_q <= grant_q;
    end
  end

  // FIFO read data lands one cycle after rd_en, so it is forwarded straight through.
  assign out_valid = ov_q;
  assign out_data  = ov_q ? fifo_data[vgrant_q*W_WIDTH +: W_WIDTH] : '0;
  assign grant     = grant_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_out_port_sched.sv
// tb_out_port_sched: cycle table for a split burst, directed corner sequences and randomized
// FIFO contents checked against a transaction-level scheduling model.
module tb_out_port_sched;

  localparam int NP    = 4;
  localparam int W     = 8;
  localparam int BL    = 4;
  localparam int GW    = 2;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NP-1:0]   fifo_empty;
  logic [NP*W-1:0] fifo_data;
  logic            out_full;
  logic [NP-1:0]   rd_en;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [GW-1:0]   grant;
  logic            busy;

  out_port_sched #(.NUM_PORTS(NP), .W_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .out_full(out_full), .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          full;
    logic [NP-1:0] rd;
    logic          ov;
    logic [W-1:0]  od;
    logic [GW-1:0] g;
    logic          b;
  } vec_t;

  vec_t          tbl[11];
  logic [W-1:0]  fmem[NP][DEPTH];
  int            fhead[NP];
  int            ftail[NP];
  logic [W-1:0]  exp_q[$];
  int            exp_g[$];
  int            glog[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            m_rr, full_mode, pops_seen, stall_left, ov_cnt;
  bit            prev_busy, sb_on, refill;
  logic [NP-1:0] rd_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic push_word(input int p, input logic [W-1:0] w);
    fmem[p][ftail[p] % DEPTH] = w;
    ftail[p]++;
  endtask

  task automatic upd_empty();
    for (int p = 0; p < NP; p++) fifo_empty[p] = (ftail[p] == fhead[p]);
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (ftail[p] != fhead[p]) return 1'b0;
    return 1'b1;
  endfunction

  // Transaction-level model: whole bursts of min(BL, remaining) words, chosen by the arbitration rule.
  task automatic predict();
    int len[NP];
    int hd[NP];
    int p, n;
    for (int i = 0; i < NP; i++) begin
      len[i] = ftail[i] - fhead[i];
      hd[i]  = fhead[i];
    end
    forever begin
      p = -1;
`ifdef SCHED_PRIO_EN
      if (len[0] > 0) p = 0;
`endif
      for (int k = 0; k < NP; k++) begin
        if (p < 0 && len[(m_rr + k) % NP] > 0) p = (m_rr + k) % NP;
      end
      if (p < 0) break;
      exp_g.push_back(p);
      n = (len[p] < BL) ? len[p] : BL;
      for (int j = 0; j < n; j++) exp_q.push_back(fmem[p][(hd[p] + j) % DEPTH]);
      hd[p]  += n;
      len[p] -= n;
`ifdef SCHED_PRIO_EN
      if (p != 0) m_rr = (p + 1) % NP;
`else
      m_rr = (p + 1) % NP;
`endif
    end
  endtask

  task automatic step_edge();
    rd_s = rd_en;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rd_s[p] && ftail[p] != fhead[p]) begin
        fifo_data[p*W +: W] = fmem[p][fhead[p] % DEPTH];
        fhead[p]++;
        pops_seen++;
        if (refill) push_word(p, W'($urandom));
      end
    end
    upd_empty();
  endtask

  task automatic cycle_io();
    bit ok;
    case (full_mode)
      1: out_full = ($urandom_range(0, 3) == 0);
      2: begin
        out_full = (pops_seen >= 2 && stall_left > 0);
        if (out_full) stall_left--;
      end
      default: out_full = 1'b0;
    endcase
    #4;
    ok = ((rd_en & (rd_en - 1'b1)) == '0) && ((rd_en & fifo_empty) == '0) &&
         !(out_full && |rd_en) && !(!busy && |rd_en) &&
         (rd_en == '0 || rd_en == (NP'(1) << grant)) && (out_valid || out_data == '0);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL protocol: got rd_en=%b empty=%b full=%b grant=%0d busy=%b ov=%b od=%h, required single pop to granted non-empty port only while busy and not full, od=0 when idle",
               rd_en, fifo_empty, out_full, grant, busy, out_valid, out_data);
    end
    if (busy && !prev_busy) begin
      glog.push_back(int'(grant));
      if (sb_on) begin
        if (exp_g.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL grant: got unexpected burst on port %0d, required none", grant);
        end else check("grant", 32'(grant), 32'(exp_g.pop_front()));
      end
    end
    prev_busy = busy;
    if (out_valid) begin
      ov_cnt++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL data: got extra word 0x%h, required no word", out_data);
        end else check("data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    step_edge();
  endtask

  task automatic run_until_idle(input int max_cyc, input string name);
    int c = 0;
    while (!(exp_q.size() == 0 && all_empty() && !busy) && c < max_cyc) begin
      cycle_io();
      c++;
    end
    if (c >= max_cyc) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), c);
    end
    repeat (3) cycle_io();
    check({name, "_grants_left"}, 32'(exp_g.size()), 0);
    check({name, "_words_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    exp_g.delete();
  endtask

  task automatic reset_dut();
    rst_n     = 1'b1;
    out_full  = 1'b0;
    fifo_data = '0;
    for (int p = 0; p < NP; p++) begin
      fhead[p] = 0;
      ftail[p] = 0;
    end
    upd_empty();
    exp_q.delete(); exp_g.delete(); glog.delete();
    m_rr = 0; prev_busy = 1'b0; full_mode = 0; refill = 1'b0; sb_on = 1'b1;
    ov_cnt = 0; pops_seen = 0; stall_left = 0;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", 32'({rd_en, out_valid, out_data, grant, busy}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ge;
    // Port 2 with 6 words: a full burst, one idle bubble, then the 2-word remainder.
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1};
    tbl[2]  = '{1'b0, 4'b0100, 1'b1, 8'h10, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 8'h13, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 4'b0100, 1'b1, 8'h14, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 8'h15, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};

    reset_dut();
    for (int k = 0; k < 6; k++) push_word(2, W'(8'h10 + k));
    upd_empty();
    for (int i = 0; i < 11; i++) begin
      out_full = tbl[i].full;
      #4;
      vectors++;
      if ({rd_en, out_valid, out_data, grant, busy} !==
          {tbl[i].rd, tbl[i].ov, tbl[i].od, tbl[i].g, tbl[i].b}) begin
        miscompares++;
        $display("FAIL vec%0d: got rd_en=%b ov=%b od=%h grant=%0d busy=%b, required rd_en=%b ov=%b od=%h grant=%0d busy=%b",
                 i, rd_en, out_valid, out_data, grant, busy,
                 tbl[i].rd, tbl[i].ov, tbl[i].od, tbl[i].g, tbl[i].b);
      end
      step_edge();
    end

    // All four ports full after reset: grants 0..3, 16 words, pointer back at 0.
    reset_dut();
    for (int p = 0; p < NP; p++) for (int k = 0; k < 4; k++) push_word(p, W'(p * 16 + k));
    upd_empty();
    predict();
    run_until_idle(200, "rr4");
    check("rr4_pulses", 32'(ov_cnt), 16);
    check("rr4_grant_count", 32'(glog.size()), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("rr4_grant_order", 32'(glog[i]), 32'(i));
    glog.delete();
    push_word(0, 8'hE0); push_word(1, 8'hE1);
    upd_empty();
    predict();
    run_until_idle(100, "rr4_ptr");
    check("rr4_ptr_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 0);

    // Short burst ends on empty; pointer moves to 2.
    reset_dut();
    push_word(1, 8'h51); push_word(1, 8'h52);
    upd_empty();
    predict();
    run_until_idle(100, "short");
    check("short_pulses", 32'(ov_cnt), 2);
    glog.delete();
    push_word(1, 8'h61); push_word(2, 8'h62);
    upd_empty();
    predict();
    run_until_idle(100, "short_ptr");
    check("short_ptr_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 2);

    // Three cycles of backpressure in the middle of a burst.
    reset_dut();
    for (int k = 0; k < 6; k++) push_word(0, W'(8'h30 + k));
    upd_empty();
    full_mode  = 2;
    stall_left = 3;
    predict();
    run_until_idle(100, "stall");
    check("stall_bursts", 32'(glog.size()), 2);
    check("stall_pulses", 32'(ov_cnt), 6);

    // Reset at the second word of a burst; arbitration restarts from port 0.
    reset_dut();
    push_word(1, 8'h71); push_word(1, 8'h72);
    upd_empty();
    predict();
    run_until_idle(100, "pre_rst");
    for (int k = 0; k < 4; k++) push_word(2, W'(8'hA0 + k));
    upd_empty();
    predict();
    cycle_io();
    cycle_io();
    rst_n = 1'b0;
    #1 check("midburst_reset_outputs", 32'({rd_en, out_valid, out_data, grant, busy}), 0);
    exp_q.delete(); exp_g.delete(); glog.delete();
    m_rr = 0;
    prev_busy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_word(0, 8'hB0); push_word(0, 8'hB1);
    upd_empty();
    predict();
    run_until_idle(100, "post_rst");
    check("post_rst_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 0);

    // Ports 0 and 3 kept non-empty: priority build always picks 0, otherwise they alternate.
    reset_dut();
    sb_on  = 1'b0;
    refill = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_word(0, W'($urandom));
      push_word(3, W'($urandom));
    end
    upd_empty();
    for (int c = 0; c < 300 && glog.size() < 6; c++) cycle_io();
    check("refill_grant_count", 32'(glog.size() >= 6), 1);
    for (int i = 0; i < 6; i++) begin
`ifdef SCHED_PRIO_EN
      ge = 0;
`else
      ge = (i % 2 == 0) ? 0 : 3;
`endif
      check("refill_grant", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(ge));
    end

    // Randomized FIFO contents with random backpressure.
    reset_dut();
    full_mode = 1;
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < NP; p++) begin
        int n;
        n = $urandom_range(0, 9);
        for (int k = 0; k < n; k++) push_word(p, W'($urandom));
      end
      upd_empty();
      predict();
      run_until_idle(600, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
